// File: rtl/bin2seg_encoder_pkg.sv
// Shared types and constants for the binary-to-7-segment encoder.
// Contents: FSM state encoding, active-low segment codes (bit0=a .. bit6=g, 0=lit),
// and a constant function for powers of ten used to derive the overflow limit.
package disp_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

    // 10^n, evaluated at elaboration time for the overflow threshold
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2seg_encoder_if.sv
// Request/response bundle of the binary-to-7-segment encoder.
// Signals: bin_i/valid_i (request), ready_o (idle), done_o (result pulse),
// number_o (DIGITS active-low 7-seg patterns, digit k at [7k+6:7k]).
// master: requester side; slave: encoder side.
interface bin2seg_encoder_if #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned DIGITS = 8
);
    logic [WIDTH-1:0]    bin_i;
    logic                valid_i;
    logic                ready_o;
    logic                done_o;
    logic [7*DIGITS-1:0] number_o;

    modport master (output bin_i, output valid_i,
                    input  ready_o, input done_o, input number_o);
    modport slave  (input  bin_i, input valid_i,
                    output ready_o, output done_o, output number_o);
endinterface

// File: rtl/bin2seg_encoder_seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-low 7-segment pattern.
// Ports: i_bcd (4-bit BCD digit), o_seg_c (gfedcba, 0=lit). Codes above 9 show blank.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [NIB_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin : decode
        o_seg_c = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin2seg_encoder.sv
// bin2seg_encoder: sequential double-dabble conversion of an unsigned binary value
// into DIGITS active-low 7-segment patterns for a multiplexed display scanner.
// Ports: clk_i (clock), rst_ni (async active-low reset), bus (bin2seg_encoder_if.slave:
// bin_i, valid_i, ready_o, done_o, number_o).
// One shift per clock; result appears WIDTH+1 cycles after accept with a done_o pulse
// and is held until the next conversion completes.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant
// nonzero digit (digit 0 always shown); otherwise all digits are zero-padded.
module bin2seg_encoder
    import disp_pkg::*;
#(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned DIGITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    bin2seg_encoder_if.slave   bus
);

    localparam int unsigned BCD_W = NIB_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + WIDTH;
    localparam int unsigned NUM_W = SEG_W * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    state_t             r_state;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [NUM_W-1:0]   r_number;
    logic               r_done;
    logic               r_ready;

    state_t             w_state_nxt;
    logic [SR_W-1:0]    w_sr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;
    logic [NUM_W-1:0]   w_number_nxt;
    logic               w_done_nxt;
    logic               w_ready_nxt;

    logic [SR_W-1:0]    w_sr_adj;
    logic [SEG_W-1:0]   w_seg [DIGITS];
    logic [NUM_W-1:0]   w_digits;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin : bcd_adjust
        w_sr_adj = r_sr;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_sr[WIDTH + NIB_W*k +: NIB_W] >= 4'd5) begin
                w_sr_adj[WIDTH + NIB_W*k +: NIB_W] = r_sr[WIDTH + NIB_W*k +: NIB_W] + 4'd3;
            end
        end
    end

    // One decoder per digit, fed from the BCD half of the shift register
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
        seg7_decode u_dec (
            .i_bcd   (r_sr[WIDTH + NIB_W*g +: NIB_W]),
            .o_seg_c (w_seg[g])
        );
    end

    // Final digit selection: overflow dash, optional leading-zero blanking
    always_comb begin : digit_select
`ifdef LEADING_ZERO_BLANK_EN
        logic seen_nz;
        seen_nz = 1'b0;
`endif
        w_digits = '1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (r_sr[WIDTH + NIB_W*k +: NIB_W] != 4'd0) begin
                seen_nz = 1'b1;
            end
`endif
            if (r_ovf) begin
                w_digits[SEG_W*k +: SEG_W] = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
            end else if (!seen_nz && (k != 0)) begin
                w_digits[SEG_W*k +: SEG_W] = SEG_BLANK;
`endif
            end else begin
                w_digits[SEG_W*k +: SEG_W] = w_seg[k];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin : fsm_next
        w_state_nxt  = r_state;
        w_sr_nxt     = r_sr;
        w_cnt_nxt    = r_cnt;
        w_ovf_nxt    = r_ovf;
        w_number_nxt = r_number;
        w_done_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.valid_i) begin
                    w_sr_nxt    = {BCD_W'(0), bus.bin_i};
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = (64'(bus.bin_i) > MAX_VAL);
                    w_state_nxt = SHIFT;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                w_sr_nxt  = {w_sr_adj[SR_W-2:0], 1'b0};
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                w_number_nxt = w_digits;
                w_done_nxt   = 1'b1;
                w_ready_nxt  = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin : fsm_regs
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_number <= '1;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_sr     <= w_sr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_number <= w_number_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign bus.ready_o  = r_ready;
    assign bus.done_o   = r_done;
    assign bus.number_o = r_number;

endmodule
